// File: rtl/adc_sample_gearbox_4to1.sv
// adc_sample_gearbox_4to1: packs RATIO consecutive ADC samples into one wide word.
// Each word holds for at least RATIO sample clocks, and WORD_TGL flips once per new
// word, so logic on the CLK/RATIO divider output can capture WORD_OUT safely.
// A SLIP rising edge drops one sample to shift the word alignment.
module adc_sample_gearbox_4to1 #(
    parameter int SAMPLE_W = 14,
    parameter int RATIO    = 4,
    parameter int IDX_W    = 3,
    parameter int CNT_W    = 16
) (
    input  logic                      CLK,
    input  logic                      RESET_N,
    input  logic                      ENABLE,
    input  logic [SAMPLE_W-1:0]       SAMPLE_IN,
    input  logic                      SAMPLE_VALID,
    input  logic                      SLIP,
    output logic [RATIO*SAMPLE_W-1:0] WORD_OUT,
    output logic                      WORD_VALID,
    output logic                      WORD_TGL,
    output logic [IDX_W-1:0]          LANE_IDX,
    output logic                      SLIP_BUSY,
    output logic [CNT_W-1:0]          WORD_CNT
);

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_FILL     = 2'd1,
        ST_SKIP     = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Partial word; lane 0 is the oldest sample, matching the WORD_OUT lane order.
    logic [RATIO-1:0][SAMPLE_W-1:0] lanes, lanes_nxt;

    logic slip_q;
    logic slip_edge;
    logic store;     // sample written into lane LANE_IDX
    logic complete;  // this sample closes the word
    logic discard;   // sample dropped by an armed slip
    logic arm;       // slip edge accepted this cycle

    assign slip_edge = SLIP & ~slip_q;

    // State register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state <= ST_DISABLED;
        else          state <= state_nxt;
    end

    // Next state and per-cycle control strobes; ENABLE low overrides everything
    // except a word that completes in the same cycle.
    always_comb begin
        state_nxt = state;
        store     = 1'b0;
        complete  = 1'b0;
        discard   = 1'b0;
        arm       = 1'b0;
        case (state)
            ST_DISABLED: begin
                if (ENABLE) state_nxt = ST_FILL;
            end
            ST_FILL: begin
                store    = SAMPLE_VALID;
                complete = SAMPLE_VALID && (LANE_IDX == IDX_W'(RATIO - 1));
                // The sample arriving with the edge is still kept; the next one is dropped.
                arm      = slip_edge && !SLIP_BUSY;
                if (arm) state_nxt = ST_SKIP;
            end
            ST_SKIP: begin
                discard = SAMPLE_VALID;
                if (discard) state_nxt = ST_FILL;
            end
            default: state_nxt = ST_DISABLED;
        endcase
        if (!ENABLE) begin
            state_nxt = ST_DISABLED;
            arm       = 1'b0;
        end
    end

    // Partial word with the current sample written into its lane.
    always_comb begin
        lanes_nxt = lanes;
        for (int k = 0; k < RATIO; k++) begin
            if (LANE_IDX == IDX_W'(k)) lanes_nxt[k] = SAMPLE_IN;
        end
    end

    // Datapath: lane fill, word publish, toggle/count and slip bookkeeping.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            lanes      <= '0;
            LANE_IDX   <= '0;
            WORD_OUT   <= '0;
            WORD_VALID <= 1'b0;
            WORD_TGL   <= 1'b0;
            WORD_CNT   <= '0;
            SLIP_BUSY  <= 1'b0;
            slip_q     <= 1'b0;
        end else begin
            slip_q     <= SLIP;
            WORD_VALID <= complete;
            if (complete) begin
                WORD_OUT <= lanes_nxt;
                WORD_TGL <= ~WORD_TGL;
                WORD_CNT <= WORD_CNT + CNT_W'(1);
            end
            if (!ENABLE) begin
                // Flush: the partial word is dropped, published word state is kept.
                lanes     <= '0;
                LANE_IDX  <= '0;
                SLIP_BUSY <= 1'b0;
            end else begin
                if (store) begin
                    lanes    <= lanes_nxt;
                    LANE_IDX <= complete ? '0 : LANE_IDX + IDX_W'(1);
                end
                if (arm)          SLIP_BUSY <= 1'b1;
                else if (discard) SLIP_BUSY <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_adc_sample_gearbox_4to1.sv
// Bench for adc_sample_gearbox_4to1: directed vectors, expected words queued by the
// stimulus and checked by a separate monitor whenever WORD_VALID is seen.
module tb_adc_sample_gearbox_4to1;

    localparam int SW = 14;
    localparam int R  = 4;
    localparam int IW = 3;
    localparam int CW = 4;   // small counter so the wrap is reachable

    logic          CLK = 1'b0;
    logic          RESET_N = 1'b0;
    logic          ENABLE = 1'b0;
    logic [SW-1:0] SAMPLE_IN = '0;
    logic          SAMPLE_VALID = 1'b0;
    logic          SLIP = 1'b0;
    logic [R*SW-1:0] WORD_OUT;
    logic          WORD_VALID;
    logic          WORD_TGL;
    logic [IW-1:0] LANE_IDX;
    logic          SLIP_BUSY;
    logic [CW-1:0] WORD_CNT;

    adc_sample_gearbox_4to1 #(.SAMPLE_W(SW), .RATIO(R), .IDX_W(IW), .CNT_W(CW)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .ENABLE(ENABLE), .SAMPLE_IN(SAMPLE_IN),
        .SAMPLE_VALID(SAMPLE_VALID), .SLIP(SLIP), .WORD_OUT(WORD_OUT),
        .WORD_VALID(WORD_VALID), .WORD_TGL(WORD_TGL), .LANE_IDX(LANE_IDX),
        .SLIP_BUSY(SLIP_BUSY), .WORD_CNT(WORD_CNT)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [R*SW-1:0] w;
        logic [CW-1:0]   c;
        logic            t;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    int            checks = 0;
    int            passed = 0;
    logic [CW-1:0] m_cnt = '0;
    logic          m_tgl = 1'b0;

    function automatic logic [R*SW-1:0] pack(input int a, input int b, input int c, input int d);
        return {SW'(d), SW'(c), SW'(b), SW'(a)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    // Drive one cycle of inputs; returns 1 time unit after the capturing edge.
    task automatic cyc(input logic en, input logic v, input int s, input logic sl);
        ENABLE = en; SAMPLE_VALID = v; SAMPLE_IN = SW'(s); SLIP = sl;
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input int a, input int b, input int c, input int d);
        m_cnt = m_cnt + CW'(1);
        m_tgl = ~m_tgl;
        sb.push_back('{w: pack(a, b, c, d), c: m_cnt, t: m_tgl});
    endtask

    // Monitor: every published word must match the head of the scoreboard.
    always @(negedge CLK) begin
        if (RESET_N && WORD_VALID) begin
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL unexpected_word: got %0h expected none", WORD_OUT);
            end else begin
                mon_e = sb.pop_front();
                chk("word_out", 64'(WORD_OUT), 64'(mon_e.w));
                chk("word_cnt", 64'(WORD_CNT), 64'(mon_e.c));
                chk("word_tgl", 64'(WORD_TGL), 64'(mon_e.t));
            end
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_word_out"}, 64'(WORD_OUT), 64'd0);
        chk({tag, "_word_valid"}, 64'(WORD_VALID), 64'd0);
        chk({tag, "_word_tgl"}, 64'(WORD_TGL), 64'd0);
        chk({tag, "_lane_idx"}, 64'(LANE_IDX), 64'd0);
        chk({tag, "_slip_busy"}, 64'(SLIP_BUSY), 64'd0);
        chk({tag, "_word_cnt"}, 64'(WORD_CNT), 64'd0);
    endtask

    initial begin
        // Reset state
        @(posedge CLK); #1;
        chk_zero("reset");
        #3 RESET_N = 1'b1;
        @(posedge CLK); #1;
        cyc(1, 0, 0, 0);                       // DISABLED -> FILL

        // Back-to-back word 1,2,3,4
        cyc(1, 1, 1, 0); cyc(1, 1, 2, 0); cyc(1, 1, 3, 0);
        push(1, 2, 3, 4);
        cyc(1, 1, 4, 0);
        chk("latency_valid", 64'(WORD_VALID), 64'd1);
        chk("lane_after_word", 64'(LANE_IDX), 64'd0);
        cyc(1, 0, 0, 0);
        chk("valid_one_cycle", 64'(WORD_VALID), 64'd0);

        // Gapped word 5,_,6,_,_,7,8
        cyc(1, 1, 5, 0);
        chk("lane_after_5", 64'(LANE_IDX), 64'd1);
        cyc(1, 0, 0, 0);
        chk("lane_gap1", 64'(LANE_IDX), 64'd1);
        chk("word_hold_gap1", 64'(WORD_OUT), 64'(pack(1, 2, 3, 4)));
        cyc(1, 1, 6, 0); cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
        chk("lane_gap3", 64'(LANE_IDX), 64'd2);
        chk("word_hold_gap3", 64'(WORD_OUT), 64'(pack(1, 2, 3, 4)));
        cyc(1, 1, 7, 0);
        push(5, 6, 7, 8);
        cyc(1, 1, 8, 0);

        // Slip edge, SLIP held high, 10 discarded
        cyc(1, 0, 0, 1);
        chk("slip_busy_set", 64'(SLIP_BUSY), 64'd1);
        cyc(1, 0, 0, 1);
        chk("slip_busy_held", 64'(SLIP_BUSY), 64'd1);
        cyc(1, 1, 10, 1);
        chk("slip_busy_clear", 64'(SLIP_BUSY), 64'd0);
        chk("lane_after_discard", 64'(LANE_IDX), 64'd0);
        cyc(1, 1, 11, 1);
        chk("slip_held_no_rearm", 64'(SLIP_BUSY), 64'd0);
        cyc(1, 1, 12, 0); cyc(1, 1, 13, 0);
        push(11, 12, 13, 14);
        cyc(1, 1, 14, 0);

        // Slip edge together with a valid sample: 30 kept, 31 dropped
        cyc(1, 1, 30, 1);
        chk("slip_same_cycle_lane", 64'(LANE_IDX), 64'd1);
        chk("slip_same_cycle_busy", 64'(SLIP_BUSY), 64'd1);
        cyc(1, 1, 31, 1);
        chk("slip_same_cycle_drop", 64'(LANE_IDX), 64'd1);
        cyc(1, 1, 32, 0); cyc(1, 1, 33, 0);
        push(30, 32, 33, 34);
        cyc(1, 1, 34, 0);

        // Flush after two samples; slip and samples ignored while disabled
        cyc(1, 1, 40, 0); cyc(1, 1, 41, 0);
        cyc(0, 0, 0, 0);
        chk("flush_lane", 64'(LANE_IDX), 64'd0);
        chk("flush_word_hold", 64'(WORD_OUT), 64'(pack(30, 32, 33, 34)));
        cyc(0, 1, 99, 1);
        chk("disabled_slip_ignored", 64'(SLIP_BUSY), 64'd0);
        chk("disabled_sample_ignored", 64'(LANE_IDX), 64'd0);
        cyc(1, 0, 0, 0);
        cyc(1, 1, 20, 0); cyc(1, 1, 21, 0); cyc(1, 1, 22, 0);
        push(20, 21, 22, 23);
        cyc(1, 1, 23, 0);

        // ENABLE falls on the completing sample: word still completes
        cyc(1, 1, 50, 0); cyc(1, 1, 51, 0); cyc(1, 1, 52, 0);
        push(50, 51, 52, 53);
        cyc(0, 1, 53, 0);
        chk("en_fall_complete", 64'(WORD_VALID), 64'd1);
        cyc(0, 0, 0, 0);
        chk("en_fall_single", 64'(WORD_VALID), 64'd0);
        cyc(1, 0, 0, 0);

        // Asynchronous reset mid-word
        cyc(1, 1, 60, 0); cyc(1, 1, 61, 0);
        #2 RESET_N = 1'b0;
        #1 chk_zero("async_reset");
        m_cnt = '0; m_tgl = 1'b0;
        ENABLE = 1'b1; SAMPLE_VALID = 1'b0; SLIP = 1'b0;
        @(posedge CLK); #3 RESET_N = 1'b1;
        @(posedge CLK); #1;                    // DISABLED -> FILL
        cyc(1, 1, 70, 0); cyc(1, 1, 71, 0); cyc(1, 1, 72, 0);
        push(70, 71, 72, 73);
        cyc(1, 1, 73, 0);

        // 15 more words: counter wraps to 0 and the toggle parity follows
        for (int i = 0; i < 15; i++) begin
            for (int k = 0; k < 3; k++) cyc(1, 1, 100 + i * 4 + k, 0);
            push(100 + i * 4, 101 + i * 4, 102 + i * 4, 103 + i * 4);
            cyc(1, 1, 103 + i * 4, 0);
        end
        chk("cnt_wrap", 64'(WORD_CNT), 64'd0);
        chk("tgl_parity", 64'(WORD_TGL), 64'd0);

        cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
        checks++;
        if (sb.size() == 0) passed++;
        else $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
